// File: rtl/factor_engine_if.sv
// factor_engine_if: valid/ready bundle between number source, engine and
// result consumer. The engine uses the slave modport; the environment uses master.
// Ports (via modports):
//   in_valid/in_ready/in_number      input number handshake
//   out_valid/out_ready/out_number   result handshake and echoed number
//   out_factors                      bit i set when (i+2) divides out_number
//   out_prime                        only when FACTOR_ENGINE_PRIME_EN is defined
interface factor_engine_if #(
  parameter int WIDTH   = 7,
  parameter int MAX_DIV = 9
);
  localparam int NUM_DIV = MAX_DIV - 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_number;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_number;
  logic [NUM_DIV-1:0] out_factors;
`ifdef FACTOR_ENGINE_PRIME_EN
  logic               out_prime;

  modport master (
    output in_valid, in_number, out_ready,
    input  in_ready, out_valid, out_number,
    input  out_factors, out_prime
  );

  modport slave (
    input  in_valid, in_number, out_ready,
    output in_ready, out_valid, out_number,
    output out_factors, out_prime
  );
`else
  modport master (
    output in_valid, in_number, out_ready,
    input  in_ready, out_valid, out_number,
    input  out_factors
  );

  modport slave (
    input  in_valid, in_number, out_ready,
    output in_ready, out_valid, out_number,
    output out_factors
  );
`endif
endinterface

// File: rtl/factor_engine.sv
// factor_engine: bit-serial divisibility test of one WIDTH-bit number
// against every divisor 2..MAX_DIV, MSB first, one bit per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    factor_engine_if.slave (input and result handshakes)
// Optional macro FACTOR_ENGINE_PRIME_EN adds bus.out_prime
// ("no divisor in 2..min(MAX_DIV,n-1)" and n >= 2).
module factor_engine #(
  parameter int WIDTH   = 7,
  parameter int MAX_DIV = 9
) (
  input  logic            clk,
  input  logic            reset,
  factor_engine_if.slave  bus
);
  localparam int NUM_DIV = MAX_DIV - 1;
  localparam int RW      = $clog2(MAX_DIV);
  localparam int TW      = RW + 1;
  localparam int CW      = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   num_q;
  logic [CW-1:0]      cnt;
  logic [RW-1:0]      res     [NUM_DIV];
  logic [RW-1:0]      res_nxt [NUM_DIV];
  logic [NUM_DIV-1:0] fac_nxt;
  logic               bit_in;
  logic               last;
  logic [WIDTH-1:0]   number;
  logic [NUM_DIV-1:0] factors;

  assign bit_in = num_q[cnt];
  assign last   = (cnt == '0);

  // One conditional subtract per divisor: r < d so 2r+b < 2d.
  always_comb begin
    logic [TW-1:0] t;
    logic [TW-1:0] d;
    t       = '0;
    d       = '0;
    fac_nxt = '0;
    for (int i = 0; i < NUM_DIV; i++) begin
      t = {res[i], bit_in};
      d = TW'(i + 2);
      if (t >= d) begin
        res_nxt[i] = RW'(t - d);
      end else begin
        res_nxt[i] = RW'(t);
      end
      fac_nxt[i] = (res_nxt[i] == '0);
    end
  end

`ifdef FACTOR_ENGINE_PRIME_EN
  localparam int KW = (WIDTH > 32) ? WIDTH + 1 : 33;

  logic [NUM_DIV-1:0] below;
  logic               prime_nxt;
  logic               prime;

  // Only divisors strictly below n count, so n itself may be prime.
  always_comb begin
    below = '0;
    for (int i = 0; i < NUM_DIV; i++) begin
      below[i] = (KW'(i + 2) < KW'(num_q));
    end
    prime_nxt = (KW'(num_q) >= KW'(2))
             && ((fac_nxt & below) == '0);
  end

  assign bus.out_prime = prime;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q   <= '0;
      cnt     <= '0;
      number  <= '0;
      factors <= '0;
      for (int i = 0; i < NUM_DIV; i++) begin
        res[i] <= '0;
      end
`ifdef FACTOR_ENGINE_PRIME_EN
      prime   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && bus.in_valid) begin
        num_q <= bus.in_number;
        cnt   <= CW'(WIDTH - 1);
        for (int i = 0; i < NUM_DIV; i++) begin
          res[i] <= '0;
        end
      end
      if (state == CALC) begin
        for (int i = 0; i < NUM_DIV; i++) begin
          res[i] <= res_nxt[i];
        end
        if (!last) begin
          cnt <= cnt - 1'b1;
        end else begin
          number  <= num_q;
          factors <= fac_nxt;
`ifdef FACTOR_ENGINE_PRIME_EN
          prime   <= prime_nxt;
`endif
        end
      end
    end
  end

  assign bus.out_number  = number;
  assign bus.out_factors = factors;

endmodule
